// File: rtl/half_add_sub_seq.sv
// Sequencer driving an ap_ctrl_hs half adder/subtractor through all {sub,a,b} operand combinations and checking its results.
// Latency: 2 cycles per transaction with a combinational stage; backpressure: ap_start held until ready/done, per-transaction timeout.
module half_add_sub_seq #(
    parameter int NUM_TXN = 8,
    parameter int TIMEOUT = 16
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       run,
    output logic       dut_ap_start,
    input  logic       dut_ap_ready,
    input  logic       dut_ap_done,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_sub,
    input  logic       dut_res,
    input  logic       dut_co,
    output logic       busy,
    output logic       finish,
    output logic [7:0] txn_count,
    output logic [7:0] err_count,
    output logic       timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    logic [2:0] state;
    logic [2:0] idx;
    logic [7:0] cyc;
    logic       tmo_hit;
    logic       res_q;
    logic       co_q;
    logic       rst_q;
    logic       exp_res;
    logic       exp_co;
    logic       mismatch;
    logic [7:0] txn_next;

    // Single release stage: the FSM can first move on the second edge after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_q <= 1'b0;
        else           rst_q <= 1'b1;
    end

    assign {dut_sub, dut_a, dut_b} = idx;
    assign dut_ap_start = (state == S_START);
    assign busy         = (state != S_IDLE);
    assign finish       = (state == S_FINISH);

    assign exp_res  = dut_a ^ dut_b;
    assign exp_co   = dut_sub ? (~dut_a & dut_b) : (dut_a & dut_b);
    assign mismatch = tmo_hit || (res_q != exp_res) || (co_q != exp_co);
    assign txn_next = txn_count + 8'd1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            cyc       <= 8'd0;
            tmo_hit   <= 1'b0;
            res_q     <= 1'b0;
            co_q      <= 1'b0;
            txn_count <= 8'd0;
            err_count <= 8'd0;
            timeout   <= 1'b0;
        end else if (rst_q) begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state     <= S_START;
                        idx       <= 3'd0;
                        cyc       <= 8'd0;
                        tmo_hit   <= 1'b0;
                        txn_count <= 8'd0;
                        err_count <= 8'd0;
                        timeout   <= 1'b0;
                    end
                end
                S_START, S_WAIT_DONE: begin
                    cyc <= cyc + 8'd1;
                    // A done seen while still in START completes the transaction even without ready.
                    if (dut_ap_done) begin
                        res_q   <= dut_res;
                        co_q    <= dut_co;
                        tmo_hit <= 1'b0;
                        state   <= S_CHECK;
                    end else if (cyc == 8'(TIMEOUT - 1)) begin
                        tmo_hit <= 1'b1;
                        timeout <= 1'b1;
                        state   <= S_CHECK;
                    end else if (state == S_START && dut_ap_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_CHECK: begin
                    txn_count <= txn_next;
                    if (mismatch && err_count != 8'hff) err_count <= err_count + 8'd1;
                    idx <= idx + 3'd1;
                    cyc <= 8'd0;
                    if (txn_next == 8'(NUM_TXN)) state <= S_FINISH;
                    else                         state <= S_START;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_half_add_sub_seq.sv
// Bench: three sequencer instances share one behavioural downstream responder (latency, fault and timeout modes).
module tb_half_add_sub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] run_v;
    logic [2:0] start_v, busy_v, fin_v, tmo_v, a_v, b_v, s_v;
    logic [2:0] rdy_v, done_v, res_v, co_v;
    logic [7:0] txn_v [3];
    logic [7:0] err_v [3];

    int errors = 0;
    int checks = 0;

    half_add_sub_seq #(.NUM_TXN(8), .TIMEOUT(16)) u8 (
        .ap_clk(clk), .ap_rst_n(rst_n), .run(run_v[0]), .dut_ap_start(start_v[0]),
        .dut_ap_ready(rdy_v[0]), .dut_ap_done(done_v[0]), .dut_a(a_v[0]), .dut_b(b_v[0]),
        .dut_sub(s_v[0]), .dut_res(res_v[0]), .dut_co(co_v[0]), .busy(busy_v[0]),
        .finish(fin_v[0]), .txn_count(txn_v[0]), .err_count(err_v[0]), .timeout(tmo_v[0]));

    half_add_sub_seq #(.NUM_TXN(10), .TIMEOUT(16)) u10 (
        .ap_clk(clk), .ap_rst_n(rst_n), .run(run_v[1]), .dut_ap_start(start_v[1]),
        .dut_ap_ready(rdy_v[1]), .dut_ap_done(done_v[1]), .dut_a(a_v[1]), .dut_b(b_v[1]),
        .dut_sub(s_v[1]), .dut_res(res_v[1]), .dut_co(co_v[1]), .busy(busy_v[1]),
        .finish(fin_v[1]), .txn_count(txn_v[1]), .err_count(err_v[1]), .timeout(tmo_v[1]));

    half_add_sub_seq #(.NUM_TXN(2), .TIMEOUT(4)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .run(run_v[2]), .dut_ap_start(start_v[2]),
        .dut_ap_ready(rdy_v[2]), .dut_ap_done(done_v[2]), .dut_a(a_v[2]), .dut_b(b_v[2]),
        .dut_sub(s_v[2]), .dut_res(res_v[2]), .dut_co(co_v[2]), .busy(busy_v[2]),
        .finish(fin_v[2]), .txn_count(txn_v[2]), .err_count(err_v[2]), .timeout(tmo_v[2]));

    // Responder modes: 0 combinational, 1 carry forced low, 2 ready@4/done@6, 3 never done, 4 random latency + random corruption.
    logic [1:0] sel;
    int         mode;
    int         ph, sc, rd, dd;
    logic       corr;
    logic [2:0] cap;
    logic       cs, ca, cb, cs_s, cbusy, hit, rdy_o, done_o, res_o, co_o;
    logic [1:0] sum2;

    typedef struct {
        logic s, a, b, r, c, stable;
        int   sc;
    } ent_t;
    ent_t lg[$];
    ent_t e;

    always_comb begin
        cs    = start_v[sel];
        ca    = a_v[sel];
        cb    = b_v[sel];
        cs_s  = s_v[sel];
        cbusy = busy_v[sel];
        hit   = cs && (ph == rd);
        rdy_o = hit;
        done_o = (mode != 3) && ((dd == 0) ? hit : (ph == rd + dd));
        sum2  = cs_s ? (2'(ca) - 2'(cb)) : (2'(ca) + 2'(cb));
        res_o = sum2[0] ^ corr;
        co_o  = (mode == 1) ? 1'b0 : sum2[1];
        rdy_v = '0; done_v = '0; res_v = '0; co_v = '0;
        rdy_v[sel]  = rdy_o;
        done_v[sel] = done_o;
        res_v[sel]  = res_o;
        co_v[sel]   = co_o;
    end

    always @(posedge clk) begin
        if (!cbusy || done_o) begin
            if (cbusy) begin
                e.s = cs_s; e.a = ca; e.b = cb; e.r = res_o; e.c = co_o;
                e.sc = sc + (cs ? 1 : 0);
                e.stable = (ph == 0) ? 1'b1 : ({cs_s, ca, cb} == cap);
                lg.push_back(e);
            end
            ph <= 0;
            sc <= 0;
            case (mode)
                2: begin rd <= 3; dd <= 2; corr <= 1'b0; end
                4: begin
                    rd   <= $urandom_range(0, 3);
                    dd   <= $urandom_range(0, 3);
                    corr <= ($urandom_range(0, 3) == 0);
                end
                default: begin rd <= 0; dd <= 0; corr <= 1'b0; end
            endcase
        end else begin
            if (ph != 0 || cs) ph <= ph + 1;
            if (cs) sc <= sc + 1;
            if (cs && ph == 0) cap <= {cs_s, ca, cb};
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_run(input int i, input int budget, output int n);
        @(negedge clk) run_v[i] = 1'b1;
        @(negedge clk) run_v[i] = 1'b0;
        n = 1;
        while (!fin_v[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Reference: expected operands follow the transaction number mod 8; result by plain add/subtract.
    task automatic check_run(input string tag, input int i, input int ntxn, input int n,
                             input int exp_lat, input int exp_sc);
        int me = 0;
        int t, r, c;
        chk({tag, "_finish"}, int'(fin_v[i]), 1);
        if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_txn"}, int'(txn_v[i]), ntxn);
        chk({tag, "_log_len"}, lg.size(), ntxn);
        foreach (lg[k]) begin
            chk({tag, "_ops"}, int'({lg[k].s, lg[k].a, lg[k].b}), k % 8);
            if (exp_sc > 0) begin
                chk({tag, "_start_cycles"}, lg[k].sc, exp_sc);
                chk({tag, "_ops_stable"}, int'(lg[k].stable), 1);
            end
            if (lg[k].s) begin
                t = int'(lg[k].a) - int'(lg[k].b);
                r = (t < 0) ? t + 2 : t;
                c = (t < 0) ? 1 : 0;
            end else begin
                t = int'(lg[k].a) + int'(lg[k].b);
                r = t % 2;
                c = t / 2;
            end
            if (r != int'(lg[k].r) || c != int'(lg[k].c)) me++;
        end
        chk({tag, "_err"}, int'(err_v[i]), me);
        chk({tag, "_timeout"}, int'(tmo_v[i]), 0);
        @(negedge clk);
        chk({tag, "_finish_pulse"}, int'(fin_v[i]), 0);
        chk({tag, "_busy_idle"}, int'(busy_v[i]), 0);
    endtask

    initial begin
        int n;
        int fins;
        rst_n = 1'b0;
        run_v = '0;
        sel   = 2'd0;
        mode  = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_start", int'(start_v[0]), 0);
        chk("rst_ops", int'({s_v[0], a_v[0], b_v[0]}), 0);
        chk("rst_txn", int'(txn_v[0]), 0);
        chk("rst_err", int'(err_v[0]), 0);
        chk("rst_finish", int'(fin_v[0]), 0);
        chk("rst_timeout", int'(tmo_v[0]), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        lg.delete();
        do_run(0, 40, n);
        check_run("comb", 0, 8, n, 17, 1);

        mode = 1;
        lg.delete();
        do_run(0, 40, n);
        chk("co0_err_count", int'(err_v[0]), 2);
        check_run("co0", 0, 8, n, 17, 1);

        mode = 2;
        lg.delete();
        do_run(0, 100, n);
        check_run("slow", 0, 8, n, 57, 4);

        mode = 4;
        repeat (2) @(negedge clk);
        lg.delete();
        do_run(0, 200, n);
        check_run("rand", 0, 8, n, 0, 0);

        // Reset during WAIT_DONE of the third transaction.
        mode = 2;
        repeat (2) @(negedge clk);
        lg.delete();
        @(negedge clk) run_v[0] = 1'b1;
        @(negedge clk) run_v[0] = 1'b0;
        n = 0;
        while (!(lg.size() == 2 && busy_v[0] && !start_v[0] && ph != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wait_done_reached", int'(n < 100), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_v[0]), 0);
        chk("mid_rst_start", int'(start_v[0]), 0);
        chk("mid_rst_ops", int'({s_v[0], a_v[0], b_v[0]}), 0);
        chk("mid_rst_txn", int'(txn_v[0]), 0);
        chk("mid_rst_err", int'(err_v[0]), 0);
        chk("mid_rst_finish", int'(fin_v[0]), 0);
        @(negedge clk) rst_n = 1'b1;
        fins = 0;
        repeat (20) begin
            @(negedge clk);
            if (fin_v[0]) fins++;
        end
        chk("mid_rst_no_finish", fins, 0);
        mode = 0;
        lg.delete();
        do_run(0, 40, n);
        check_run("after_rst", 0, 8, n, 17, 1);

        // NUM_TXN = 10 with a second run pulse mid-run.
        sel = 2'd1;
        repeat (2) @(negedge clk);
        lg.delete();
        @(negedge clk) run_v[1] = 1'b1;
        @(negedge clk) run_v[1] = 1'b0;
        n = 1;
        while (!fin_v[1] && n < 60) begin
            run_v[1] = (n == 5);
            @(negedge clk);
            n++;
        end
        run_v[1] = 1'b0;
        check_run("wrap10", 1, 10, n, 21, 1);

        // Downstream never signals done.
        sel  = 2'd2;
        mode = 3;
        repeat (2) @(negedge clk);
        lg.delete();
        do_run(2, 60, n);
        chk("tmo_finish", int'(fin_v[2]), 1);
        chk("tmo_flag", int'(tmo_v[2]), 1);
        chk("tmo_err", int'(err_v[2]), 2);
        chk("tmo_txn", int'(txn_v[2]), 2);
        @(negedge clk);
        chk("tmo_sticky", int'(tmo_v[2]), 1);
        chk("tmo_busy_idle", int'(busy_v[2]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/half_add_sub_seq.md
HALF_ADD_SUB_SEQ -- requirements
Module: half_add_sub_seq

Interface
REQ-001 Parameter NUM_TXN, default 8, number of operand transactions per run (range 1..255).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles from ap_start assertion to ap_done (range 2..255).
REQ-003 ap_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  one-cycle pulse; begins a run when sampled high in IDLE.
REQ-006 dut_ap_start  out  1  ap_ctrl_hs start to the downstream half_add_sub stage.
REQ-007 dut_ap_ready  in  1  downstream ready.
REQ-008 dut_ap_done  in  1  downstream done, qualifies dut_res and dut_co.
REQ-009 dut_a, dut_b, dut_sub  out  1 each  operands and mode (0 = add, 1 = subtract).
REQ-010 dut_res, dut_co  in  1 each  sum/difference and carry/borrow from the downstream stage.
REQ-011 busy  out  1  high from run acceptance until finish.
REQ-012 finish  out  1  one-cycle pulse at end of run.
REQ-013 txn_count  out  8  completed transactions in the current run.
REQ-014 err_count  out  8  mismatching transactions in the current run.
REQ-015 timeout  out  1  sticky; set when a transaction exceeds TIMEOUT.

Function
REQ-016 FSM states IDLE, START, WAIT_DONE, CHECK, FINISH; encoding is free.
REQ-017 IDLE -> START when run = 1; txn_count, err_count, timeout and idx cleared in that same edge.
REQ-018 Operands are registered from a 3-bit index idx: dut_sub = idx[2], dut_a = idx[1], dut_b = idx[0]; idx wraps 7 -> 0 when NUM_TXN > 8.
REQ-019 dut_ap_start is high exactly in START; operands are stable for the whole of START and WAIT_DONE.
REQ-020 START: ap_ready = 1 and ap_done = 1 in the same cycle -> capture results, go to CHECK; ap_ready = 1 only -> WAIT_DONE; ap_start is held otherwise.
REQ-021 WAIT_DONE: ap_done = 1 -> capture dut_res/dut_co, go to CHECK; ap_done without a prior ready is never lost.
REQ-022 Expected result: res = a XOR b; co = a AND b for add; co = (NOT a) AND b for subtract (borrow).
REQ-023 CHECK lasts one cycle: txn_count += 1; err_count += 1 on any mismatch, saturating at 255; idx += 1.
REQ-024 CHECK -> FINISH when the incremented txn_count equals NUM_TXN, otherwise -> START.
REQ-025 Per-transaction cycle counter is cleared on entry to START and counts in START and WAIT_DONE; reaching TIMEOUT sets timeout, counts one error and increments txn_count, then follows REQ-024.
REQ-026 FINISH: finish = 1 for one cycle, then -> IDLE; busy = 1 in all states except IDLE.
REQ-027 run while busy is ignored; dut_ap_done or dut_ap_ready in IDLE or FINISH is ignored.
REQ-028 Latency with a combinational DUT (ready = done in the first START cycle): 2 cycles per transaction; run to finish = 2*NUM_TXN + 1 cycles.

Reset
REQ-029 ap_rst_n = 0 forces IDLE immediately; all outputs, counters and idx read 0 while reset is asserted.
REQ-030 Reset asserted mid-run abandons the run and emits no finish pulse; the next run starts from idx = 0.
REQ-031 Release of reset is synchronised internally; the first state change is possible on the second rising edge after release.

Verification
REQ-032 Combinational model (ready = done = start), NUM_TXN = 8, run pulse -> all 8 {sub,a,b} combinations issued, txn_count = 8, err_count = 0, finish 17 cycles after run.
REQ-033 Model forcing co = 0 for every transaction, NUM_TXN = 8 -> err_count = 2 (add 1+1; subtract 0-1).
REQ-034 Model gives ready after 3 cycles and done 2 cycles later -> ap_start high for exactly 4 cycles per transaction; operands stable until done; err_count = 0.
REQ-035 Model never asserts done, TIMEOUT = 4, NUM_TXN = 2 -> timeout = 1, err_count = 2, txn_count = 2, finish asserted.
REQ-036 ap_rst_n pulsed low during WAIT_DONE of transaction 3 -> outputs 0 immediately, no finish; a new run then reproduces the REQ-032 result.
REQ-037 run re-pulsed during a run, and NUM_TXN = 10 -> the extra pulse is ignored; idx wraps and transactions 9-10 reuse {0,0,0} and {0,0,1}.
